hk_dna_ctrl: RTL and testbench

HK_DNA_CTRL -- requirements
Module: hk_dna_ctrl

---
 rtl/hk_dna_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hk_dna_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hk_dna_ctrl.sv
// DNA_PORT readout controller: clocks the 57-bit device DNA out serially and publishes it on a register bus.
// Optional macro HK_DNA_IRQ_EN adds the irq_en control bit and the readout-done interrupt pulse.
`timescale 1ns/1ps
module hk_dna_ctrl #(
    parameter int unsigned DIV  = 4,
    parameter bit          AUTO = 1'b1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        dna_dout_i,
    output logic        dna_clk_o,
    output logic        dna_read_o,
    output logic        dna_shift_o,
    output logic [56:0] dna_value_o,
    output logic        dna_valid_o,
    output logic        irq_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        half_q, half_d;
    logic [5:0]  bit_q, bit_d;
    logic [56:0] sr_q, sr_d;
    logic [56:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        autoPend_q, autoPend_d;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] readMux;
    logic        irqEn;

    logic wrCtrl, wrStart, active, slotEnd, busy;

    assign wrCtrl  = sys_wen && (sys_addr[19:0] == 20'h0);
    assign wrStart = wrCtrl && sys_wdata[0];
    assign active  = (state_q == LOAD) || (state_q == SHIFT);
    assign slotEnd = (div_q == DIV_LAST);
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            div_q      <= '0;
            half_q     <= 1'b0;
            bit_q      <= '0;
            sr_q       <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            autoPend_q <= AUTO;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            autoPend_q <= autoPend_d;
        end
    end

    // Clears apply before sets so a completion or overrun in the same cycle as a W1C still sticks.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        half_d     = half_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        value_d    = value_q;
        valid_d    = valid_q;
        done_d     = done_q;
        ovr_d      = ovr_q;
        autoPend_d = autoPend_q;

        if (wrCtrl && sys_wdata[1]) done_d = 1'b0;
        if (wrCtrl && sys_wdata[3]) ovr_d = 1'b0;
        if (wrStart && busy) ovr_d = 1'b1;

        if (active) begin
            if (slotEnd) begin
                div_d  = '0;
                half_d = ~half_q;
            end else begin
                div_d = div_q + 8'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (wrStart || autoPend_q) begin
                    state_d    = LOAD;
                    div_d      = '0;
                    half_d     = 1'b0;
                    bit_d      = '0;
                    sr_d       = '0;
                    valid_d    = 1'b0;
                    autoPend_d = 1'b0;
                end
            end
            LOAD: begin
                if (slotEnd && half_q) state_d = SHIFT;
            end
            SHIFT: begin
                if (slotEnd && !half_q) sr_d = {sr_q[55:0], dna_dout_i};
                // Publish on the way into DONE so the value is visible during the DONE cycle.
                if (slotEnd && half_q) begin
                    if (bit_q == 6'd56) begin
                        state_d = DONE;
                        value_d = sr_q;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef HK_DNA_IRQ_EN
    logic irqEn_q, irq_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irqEn_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wrCtrl) irqEn_q <= sys_wdata[2];
            irq_q <= (state_q == DONE) && irqEn_q;
        end
    end

    assign irqEn = irqEn_q;
    assign irq_o = irq_q;
`else
    assign irqEn = 1'b0;
    assign irq_o = 1'b0;
`endif

    always_comb begin
        readMux = '0;
        case (sys_addr[19:0])
            20'h00:  readMux = {28'b0, ovr_q, irqEn, done_q, busy};
            20'h04:  readMux = value_q[31:0];
            20'h08:  readMux = {7'b0, value_q[56:32]};
            20'h0C:  readMux = {26'b0, bit_q};
            default: readMux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= sys_wen | sys_ren;
            rdata_q <= sys_ren ? readMux : 32'h0;
        end
    end

    logic unusedBits;
    assign unusedBits = ^{sys_addr[31:20], sys_wdata};

    assign dna_clk_o   = active && half_q;
    assign dna_read_o  = (state_q == LOAD);
    assign dna_shift_o = (state_q == SHIFT);
    assign dna_value_o = value_q;
    assign dna_valid_o = valid_q;
    assign sys_rdata   = rdata_q;
    assign sys_ack     = ack_q;
    assign sys_err     = 1'b0;

endmodule

// File: tb/tb_hk_dna_ctrl.sv
// Scoreboard bench for hk_dna_ctrl: one DIV=4/AUTO=1 instance on the bus, one DIV=1/AUTO=0 instance for fast patterns.
`timescale 1ns/1ps
module tb_hk_dna_ctrl;

`ifdef HK_DNA_IRQ_EN
    localparam logic [31:0] IRQ_BIT    = 32'h4;
    localparam int          IRQ_PULSES = 1;
`else
    localparam logic [31:0] IRQ_BIT    = 32'h0;
    localparam int          IRQ_PULSES = 0;
`endif

    localparam logic [56:0] DNA1 = 57'h0823456789ABCDE;
    localparam logic [56:0] DNA2 = 57'h1ABCDEF01234567;
    localparam logic [56:0] DNA3 = 57'h0F0E1D2C3B4A596;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic [31:0] addrA, wdataA, rdataA;
    logic        wenA, renA, ackA, errA;
    logic        dnaClkA, dnaReadA, dnaShiftA, doutA, validA, irqA;
    logic [56:0] valueA;

    logic [31:0] addrB, wdataB, rdataB;
    logic        wenB, renB, ackB, errB;
    logic        dnaClkB, dnaReadB, dnaShiftB, doutB, validB, irqB;
    logic [56:0] valueB;

    hk_dna_ctrl #(.DIV(4), .AUTO(1'b1)) dut (
        .clk_i(clk), .rstn_i(rstn), .dna_dout_i(doutA),
        .dna_clk_o(dnaClkA), .dna_read_o(dnaReadA), .dna_shift_o(dnaShiftA),
        .dna_value_o(valueA), .dna_valid_o(validA), .irq_o(irqA),
        .sys_addr(addrA), .sys_wdata(wdataA), .sys_wen(wenA), .sys_ren(renA),
        .sys_rdata(rdataA), .sys_err(errA), .sys_ack(ackA)
    );

    hk_dna_ctrl #(.DIV(1), .AUTO(1'b0)) dutFast (
        .clk_i(clk), .rstn_i(rstn), .dna_dout_i(doutB),
        .dna_clk_o(dnaClkB), .dna_read_o(dnaReadB), .dna_shift_o(dnaShiftB),
        .dna_value_o(valueB), .dna_valid_o(validB), .irq_o(irqB),
        .sys_addr(addrB), .sys_wdata(wdataB), .sys_wen(wenB), .sys_ren(renB),
        .sys_rdata(rdataB), .sys_err(errB), .sys_ack(ackB)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // DNA_PORT behavioural models: READ+CLK rise loads the word, SHIFT+CLK rise shifts, DOUT is the MSB.
    logic [56:0] modelA, regA, modelB, regB;
    logic        prevClkA, prevClkB;
    always @(posedge clk) begin
        prevClkA <= dnaClkA;
        if (dnaClkA && !prevClkA) begin
            if (dnaReadA) regA <= modelA;
            else if (dnaShiftA) regA <= {regA[55:0], 1'b0};
        end
        prevClkB <= dnaClkB;
        if (dnaClkB && !prevClkB) begin
            if (dnaReadB) regB <= modelB;
            else if (dnaShiftB) regB <= {regB[55:0], 1'b0};
        end
    end
    assign doutA = regA[56];
    assign doutB = regB[56];

    typedef struct {
        logic        chk;
        logic [31:0] data;
        string       name;
    } busExp_t;
    busExp_t     busQ[$];
    logic [56:0] dnaQ[$];

    // Bus response monitor: ack must follow every request by exactly one cycle.
    logic reqLast;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) reqLast <= 1'b0;
        else       reqLast <= wenA | renA;
    end

    always @(negedge clk) begin
        if (rstn && (reqLast || ackA)) begin
            checkOutput("sysAck", {63'b0, ackA}, {63'b0, reqLast});
            checkOutput("sysErr", {63'b0, errA}, 64'h0);
            if (ackA) begin
                if (busQ.size() == 0) begin
                    checkOutput("unexpectedAck", 64'h1, 64'h0);
                end else begin
                    busExp_t e;
                    e = busQ.pop_front();
                    if (e.chk) checkOutput(e.name, {32'b0, rdataA}, {32'b0, e.data});
                end
            end
        end
    end

    // Readout monitor: on each new valid, check latency from first LOAD cycle and the published word.
    int   loadCycle = 0;
    int   irqCount  = 0;
    logic readPrev, validPrev;
    always @(negedge clk) begin
        readPrev  <= dnaReadA;
        validPrev <= validA;
        if (irqA) irqCount <= irqCount + 1;
        if (dnaReadA && !readPrev) loadCycle <= cycle;
        if (validA && !validPrev) begin
            if (dnaQ.size() == 0) begin
                checkOutput("unexpectedValid", 64'h1, 64'h0);
            end else begin
                checkOutput("readoutLatency", 64'(cycle - loadCycle), 64'd464);
                checkOutput("dnaValue", {7'b0, valueA}, {7'b0, dnaQ.pop_front()});
            end
        end
    end

    // DNA clock period of the DIV=1 instance while shifting.
    logic prevNegClkB;
    int   lastRiseB = -1;
    always @(negedge clk) begin
        prevNegClkB <= dnaClkB;
        if (dnaShiftB) begin
            if (dnaClkB && !prevNegClkB) begin
                if (lastRiseB >= 0) checkOutput("fastClkPeriod", 64'(cycle - lastRiseB), 64'd2);
                lastRiseB <= cycle;
            end
        end else begin
            lastRiseB <= -1;
        end
    end

    task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [31:0] data,
                                 input logic chk, input logic [31:0] expData, input string name);
        @(negedge clk);
        addrA  = addr;
        wdataA = data;
        wenA   = isWrite;
        renA   = !isWrite;
        busQ.push_back('{chk, expData, name});
        @(negedge clk);
        wenA = 1'b0;
        renA = 1'b0;
    endtask

    task automatic waitValidA(input string name);
        int n = 0;
        while (!validA && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!validA) checkOutput(name, 64'h0, 64'h1);
    endtask

    task automatic runFast(input logic [56:0] pattern, input string name);
        int n = 0;
        modelB = pattern;
        @(negedge clk);
        addrB = 32'h0; wdataB = 32'h1; wenB = 1'b1;
        @(negedge clk);
        wenB = 1'b0;
        checkOutput("fastAck", {63'b0, ackB}, 64'h1);
        while (!validB && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {7'b0, valueB}, {7'b0, pattern});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [56:0] alt;
        int n;
        rstn = 1'b0;
        addrA = '0; wdataA = '0; wenA = 1'b0; renA = 1'b0;
        addrB = '0; wdataB = '0; wenB = 1'b0; renB = 1'b0;
        modelA = DNA1;
        modelB = '0;
        repeat (3) @(negedge clk);

        checkOutput("rstDnaClk",   {63'b0, dnaClkA},   64'h0);
        checkOutput("rstDnaRead",  {63'b0, dnaReadA},  64'h0);
        checkOutput("rstDnaShift", {63'b0, dnaShiftA}, 64'h0);
        checkOutput("rstValid",    {63'b0, validA},    64'h0);
        checkOutput("rstIrq",      {63'b0, irqA},      64'h0);
        checkOutput("rstAck",      {63'b0, ackA},      64'h0);
        checkOutput("rstErr",      {63'b0, errA},      64'h0);
        checkOutput("rstValue",    {7'b0, valueA},     64'h0);
        checkOutput("rstRdata",    {32'b0, rdataA},    64'h0);

        // Automatic readout after reset release.
        dnaQ.push_back(DNA1);
        rstn = 1'b1;
        waitValidA("autoReadoutTimeout");

        applyStimulus(1'b0, 32'h04, 0, 1'b1, DNA1[31:0], "readLow");
        applyStimulus(1'b0, 32'h08, 0, 1'b1, {7'b0, DNA1[56:32]}, "readHigh");
        applyStimulus(1'b0, 32'h0C, 0, 1'b1, 32'd56, "readBitCount");
        applyStimulus(1'b0, 32'h00, 0, 1'b1, 32'h2, "readStatusDone");
        applyStimulus(1'b0, 32'h40, 0, 1'b1, 32'h0, "readUnmapped");
        applyStimulus(1'b1, 32'h40, 32'hFFFF_FFFF, 1'b0, 0, "writeUnmapped");
        applyStimulus(1'b1, 32'h0C, 32'h3F, 1'b0, 0, "writeBitCount");
        applyStimulus(1'b1, 32'h00, 32'h4, 1'b0, 0, "writeIrqEn");
        applyStimulus(1'b0, 32'h00, 0, 1'b1, 32'h2 | IRQ_BIT, "readIrqEn");

        // Manual start; old value must stay published while valid drops.
        modelA = DNA2;
        dnaQ.push_back(DNA2);
        applyStimulus(1'b1, 32'h00, 32'h5, 1'b0, 0, "writeStart");
        checkOutput("validClearedOnStart", {63'b0, validA}, 64'h0);
        checkOutput("valueHeldOnStart", {7'b0, valueA}, {7'b0, DNA1});
        repeat (20) @(negedge clk);
        applyStimulus(1'b1, 32'h00, 32'h5, 1'b0, 0, "writeStartBusy");
        applyStimulus(1'b0, 32'h00, 0, 1'b1, 32'hB | IRQ_BIT, "readOverrun");
        applyStimulus(1'b1, 32'h00, 32'hC, 1'b0, 0, "writeClearOverrun");
        applyStimulus(1'b0, 32'h00, 0, 1'b1, 32'h3 | IRQ_BIT, "readOverrunCleared");
        waitValidA("manualReadoutTimeout");
        repeat (3) @(negedge clk);
        checkOutput("irqPulses", 64'(irqCount), 64'(IRQ_PULSES));
        applyStimulus(1'b1, 32'h00, 32'h2, 1'b0, 0, "writeClearDone");
        applyStimulus(1'b0, 32'h00, 0, 1'b1, 32'h0, "readStatusCleared");

        // Abort a readout with reset at SHIFT slot 20.
        applyStimulus(1'b1, 32'h00, 32'h1, 1'b0, 0, "writeStartAbort");
        n = 0;
        while (!dnaReadA && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abortLoadSeen", {63'b0, dnaReadA}, 64'h1);
        repeat (168) @(negedge clk);
        checkOutput("shiftingBeforeAbort", {63'b0, dnaShiftA}, 64'h1);
        rstn = 1'b0;
        #1;
        checkOutput("abortDnaClk",   {63'b0, dnaClkA},   64'h0);
        checkOutput("abortDnaRead",  {63'b0, dnaReadA},  64'h0);
        checkOutput("abortDnaShift", {63'b0, dnaShiftA}, 64'h0);
        checkOutput("abortValid",    {63'b0, validA},    64'h0);
        checkOutput("abortValue",    {7'b0, valueA},     64'h0);
        busQ.delete();
        @(negedge clk);
        modelA = DNA3;
        dnaQ.push_back(DNA3);
        rstn = 1'b1;
        waitValidA("restartReadoutTimeout");
        applyStimulus(1'b0, 32'h04, 0, 1'b1, DNA3[31:0], "readLowAfterAbort");
        applyStimulus(1'b0, 32'h08, 0, 1'b1, {7'b0, DNA3[56:32]}, "readHighAfterAbort");

        // DIV=1 instance: all ones, then alternating 1010... starting at the MSB.
        runFast({57{1'b1}}, "fastAllOnes");
        alt = '0;
        for (int i = 0; i < 57; i++) alt[i] = (i % 2 == 0);
        runFast(alt, "fastAlternating");
        checkOutput("fastIrqIdle", {63'b0, irqB}, 64'h0);
        checkOutput("fastErr", {63'b0, errB}, 64'h0);

        repeat (4) @(negedge clk);
        checkOutput("busQueueDrained", 64'(busQ.size()), 64'h0);
        checkOutput("dnaQueueDrained", 64'(dnaQ.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
